// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and types, used by both the vectoring engine here
// and the rotation-mode sin/cos generator.
package cordic_pkg;

   localparam int INT_WIDTH = 14;
   localparam int FRAC_BITS = 10;
   localparam int MAX_ITER  = 10;

   // Q3.10 atan(2^-k), k = 0..9
   localparam logic signed [INT_WIDTH-1:0] ATAN_LUT [MAX_ITER] = '{
      14'sd804, 14'sd475, 14'sd251, 14'sd127, 14'sd64,
      14'sd32,  14'sd16,  14'sd8,   14'sd4,   14'sd2
   };

   localparam logic signed [INT_WIDTH-1:0] PI = 14'sd3217;
   localparam int K_INV = 622;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      SCALE,
      DONE
   } state_t;

endpackage

// File: rtl/cordic_round_sat.sv
// Round-half-up, arithmetic right shift and saturation of a signed value to a
// narrower signed or unsigned result.
module cordic_round_sat #(
   parameter int IN_WIDTH   = 14,
   parameter int SHIFT      = 4,
   parameter int OUT_WIDTH  = 8,
   parameter bit SIGNED_OUT = 1'b0
) (
   input  logic signed [IN_WIDTH-1:0]  data_i,
   output logic        [OUT_WIDTH-1:0] data_o
);

   localparam int MAX_VAL = SIGNED_OUT ? (1 << (OUT_WIDTH - 1)) - 1 : (1 << OUT_WIDTH) - 1;
   localparam int MIN_VAL = SIGNED_OUT ? -(1 << (OUT_WIDTH - 1)) : 0;
   localparam int HALF    = 1 << (SHIFT - 1);

   logic signed [IN_WIDTH:0] sum;
   logic signed [IN_WIDTH:0] shifted;

   // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
   always_comb begin
      sum     = (IN_WIDTH + 1)'(data_i) + (IN_WIDTH + 1)'(HALF);
      shifted = sum >>> SHIFT;
      if (shifted > (IN_WIDTH + 1)'(MAX_VAL)) begin
         data_o = OUT_WIDTH'(MAX_VAL);
      end else if (shifted < (IN_WIDTH + 1)'(MIN_VAL)) begin
         data_o = OUT_WIDTH'(MIN_VAL);
      end else begin
         data_o = shifted[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) in Q1.6 -> magnitude (Q2.6) and
// atan2 angle (Q2.5 radians), one micro-rotation per clock.
module cordic_vectoring
   import cordic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ITER_COUNT = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] x_in,
   input  logic signed [DATA_WIDTH-1:0] y_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic        [DATA_WIDTH-1:0] mag_out,
   output logic        [DATA_WIDTH-1:0] angle_out
);

   state_t                      state_q;
   logic [3:0]                  k_q;
   logic signed [INT_WIDTH-1:0] x_q, y_q, z_q;
   logic                        zero_q;
   logic                        out_valid_q;
   logic [DATA_WIDTH-1:0]       mag_q, angle_q;

   logic signed [INT_WIDTH-1:0] x_ext, y_ext;
   logic signed [INT_WIDTH-1:0] x_cap_d, y_cap_d, z_cap_d;
   logic signed [INT_WIDTH-1:0] x_d, y_d, z_d;
   logic signed [23:0]          prod;
   logic signed [INT_WIDTH-1:0] mag_full;
   logic [DATA_WIDTH-1:0]       mag_rnd, angle_rnd;

   // Left half-plane inputs are rotated by pi first so the iterations only
   // ever have to cover +-pi/2; negating -2.0 (-2048) is exact in 14 bits.
   always_comb begin
      x_ext = INT_WIDTH'(x_in) <<< 4;
      y_ext = INT_WIDTH'(y_in) <<< 4;
      if (x_in[DATA_WIDTH-1]) begin
         x_cap_d = -x_ext;
         y_cap_d = -y_ext;
         z_cap_d = y_in[DATA_WIDTH-1] ? -PI : PI;
      end else begin
         x_cap_d = x_ext;
         y_cap_d = y_ext;
         z_cap_d = '0;
      end
   end

   always_comb begin
      if (!y_q[INT_WIDTH-1]) begin
         x_d = x_q + (y_q >>> k_q);
         y_d = y_q - (x_q >>> k_q);
         z_d = z_q + ATAN_LUT[k_q];
      end else begin
         x_d = x_q - (y_q >>> k_q);
         y_d = y_q + (x_q >>> k_q);
         z_d = z_q - ATAN_LUT[k_q];
      end
   end

   // Remove the CORDIC gain; x is non-negative here so the product fits 24 bits.
   always_comb begin
      prod     = 24'(x_q) * 24'(K_INV);
      mag_full = INT_WIDTH'(prod >>> FRAC_BITS);
   end

   cordic_round_sat #(
      .IN_WIDTH  (INT_WIDTH),
      .SHIFT     (FRAC_BITS - 6),
      .OUT_WIDTH (DATA_WIDTH),
      .SIGNED_OUT(1'b0)
   ) u_mag_round (
      .data_i(mag_full),
      .data_o(mag_rnd)
   );

   cordic_round_sat #(
      .IN_WIDTH  (INT_WIDTH),
      .SHIFT     (FRAC_BITS - 5),
      .OUT_WIDTH (DATA_WIDTH),
      .SIGNED_OUT(1'b1)
   ) u_angle_round (
      .data_i(z_q),
      .data_o(angle_rnd)
   );

   // NOTE: all sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
         mag_q       <= '0;
         angle_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_q     <= x_cap_d;
                  y_q     <= y_cap_d;
                  z_q     <= z_cap_d;
                  zero_q  <= (x_in == '0) && (y_in == '0);
                  k_q     <= '0;
                  state_q <= ITER;
               end
            end
            ITER: begin
               x_q <= x_d;
               y_q <= y_d;
               z_q <= z_d;
               if (k_q == 4'(ITER_COUNT - 1)) begin
                  state_q <= SCALE;
               end else begin
                  k_q <= k_q + 4'd1;
               end
            end
            SCALE: begin
               mag_q       <= mag_rnd;
               // atan2(0, 0) is undefined; report 0 instead of the residual sum of the LUT
               angle_q     <= zero_q ? '0 : angle_rnd;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign mag_out   = mag_q;
   assign angle_out = angle_q;

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

- Iterative CORDIC engine in vectoring mode: the inverse of the team's rotation-mode sin/cos generator.
- Takes a Cartesian pair (x, y) and returns the magnitude sqrt(x²+y²) and the angle atan2(y, x) in radians.
- Used after the sin/cos path to recover phase and amplitude; inputs use the same fixed-point format.
- One iteration per clock; valid/ready handshake on both sides.

## Interface
Parameters:
- DATA_WIDTH, 8: I/O width.
- ITER_COUNT, 10: CORDIC micro-rotations; 1..10 supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  x_in/y_in valid.
- in_ready  out  1  block can accept; high only in IDLE.
- x_in  in  DATA_WIDTH  signed Q1.6 (1 sign, 1 int, 6 frac).
- y_in  in  DATA_WIDTH  signed Q1.6.
- out_valid  out  1  results valid; held until accepted.
- out_ready  in  1  consumer accepts.
- mag_out  out  DATA_WIDTH  unsigned Q2.6 magnitude, gain-compensated.
- angle_out  out  DATA_WIDTH  signed Q2.5 radians, range [-pi, +pi].

## Operation
- **Internal width:** 14-bit signed Q3.10. Inputs are sign-extended and shifted left by 4.
- **FSM:** IDLE -> ITER -> SCALE -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid, capture the pre-rotated operands, clear iter counter k, go to ITER.
  - **Pre-rotation at capture, when x<0:**
    - x0 = -x, y0 = -y.
    - z0 = +PI (3217) if y>=0, else -PI (-3217).
  - **Pre-rotation at capture, otherwise:** x0 = x, y0 = y, z0 = 0.
  - ITER, one step per cycle for k = 0..ITER_COUNT-1. After the last step, go to SCALE.
    - **When y>=0:** x += y>>>k, y -= x>>>k, z += ATAN[k].
    - **When y<0:** x -= y>>>k, y += x>>>k, z -= ATAN[k].
    - All updates use the old x/y values (simultaneous update). Shifts are arithmetic.
  - ATAN LUT, Q3.10: 804, 475, 251, 127, 64, 32, 16, 8, 4, 2.
  - SCALE:
    - Compute mag = (x * K_INV) >>> 10, with K_INV = 622 (0.6074, Q0.10), product widened to 24 bits.
    - Round mag to Q2.6: add 8, shift right 4, saturate to [0, 255].
    - Round z to Q2.5: add 16, arithmetic shift right 5, saturate to [-128, 127].
    - Register both results, set out_valid, go to DONE.
  - DONE: hold mag_out/angle_out/out_valid stable. On out_ready, clear out_valid and go to IDLE.
- **in_valid while not in IDLE:** ignored, no capture. x_in/y_in only need to be stable in the capture cycle.
- **x=0, y=0:** mag_out=0, angle_out=0. The y>=0 branch is taken every step, and z converges to ~sum(ATAN). The output angle is forced to 0 when the captured x0 and y0 are both 0 (zero-flag register).
- **x=-2.0 (-128):** negation is exact in 14 bits; no overflow.
- **Reset low on any edge:**
  - state IDLE, k=0, out_valid=0, mag_out=0, angle_out=0, internal x/y/z=0.
  - in_ready=1 from the first cycle after reset.
  - Mid-operation reset aborts the operation silently; no output is produced.

## Timing
- **Latency:** capture at edge T; iterations on edges T+1..T+ITER_COUNT; SCALE registers outputs on edge T+ITER_COUNT+1. out_valid is high from then on, i.e. 11 cycles after the capture edge for ITER_COUNT=10.
- **Throughput:** one result per ITER_COUNT+2 cycles at best, plus a DONE hold of at least 1 cycle. No overlap: a new input is accepted no earlier than the cycle after the output handshake.
- **Output handshake:** completes on a rising edge with out_valid && out_ready. in_ready rises in the following cycle.
- in_ready and out_valid derive directly from registered state; no combinational path from in_valid or out_ready to them.

## Structure
- **Package cordic_pkg:**
  - INT_WIDTH=14, FRAC_BITS=10.
  - ATAN LUT as a localparam array.
  - PI=3217, K_INV=622.
  - State enum {IDLE, ITER, SCALE, DONE}.
  - The rotation-mode block re-uses the LUT from this package.
- **Sub-module cordic_round_sat:**
  - Parameterised on input width, shift and output signedness.
  - Performs round-half-up, shift and saturate.
  - Instantiated twice: magnitude and angle.

## Test plan
- (64, 0) -> mag_out 64, angle_out 0, both ±1 LSB. out_valid rises exactly 11 cycles after the capture edge.
- (0, 64) -> mag_out 64, angle_out 50 (pi/2). (0, -64) -> angle_out -50. All ±1 LSB.
- (64, 64) -> mag_out 90-91, angle_out 25. (-64, -64) -> angle_out -75, ±1 LSB.
- (-64, 0) -> angle_out 101 (+pi), mag 64. (-64, -1) -> angle_out -100/-101. (0, 0) -> both 0.
- Backpressure: hold out_ready=0 for 5 cycles while pulsing in_valid with new data. Outputs stay stable, in_ready stays 0, nothing is captured. After out_ready, in_ready=1 in the next cycle.
- Assert rst=0 at iteration 5, then release. out_valid never rises for the aborted input. The next input (64, 64) produces the correct result with nominal latency.
